// File: rtl/mem_access_unit.sv
// M-stage load/store unit: word-aligns accesses, performs sub-word stores as a
// two-cycle read-modify-write with a pipeline stall, and extends load data.
module mem_access_unit #(
   parameter int DM_WORDS = 3072
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   input  logic [31:0] dm_rd,
   output logic [31:0] dm_a,
   output logic [31:0] dm_wd,
   output logic        dm_we,
   output logic [31:0] dm_pc,
   output logic        stall,
   output logic [31:0] ld_data,
   output logic        ld_valid,
   output logic        exc_adel,
   output logic        exc_ades
);

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_t;

   // One bit wider than the address so 4*DM_WORDS cannot wrap.
   localparam logic [32:0] DM_BYTES = 33'(4 * DM_WORDS);

   state_t      state_q, state_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] waddr_q, waddr_d;

   logic        misaligned, oor, ok;
   logic [31:0] word_addr;
   logic [31:0] merged;
   logic [31:0] load_ext;

   assign misaligned = (req_size == 2'd1 && req_addr[0])
                    || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                    || (req_size == 2'd3);
   assign oor       = {1'b0, req_addr} >= DM_BYTES;
   assign ok        = req_valid && !misaligned && !oor;
   assign word_addr = {req_addr[31:2], 2'b00};
   assign dm_pc     = req_pc;

   assign exc_adel  = !reset && req_valid && !req_we && !ok;
   assign exc_ades  = !reset && req_valid &&  req_we && !ok;

   // Memory word with the addressed byte or half lane replaced by store data.
   always_comb begin
      merged = dm_rd;
      if (req_size == 2'd0) begin
         case (req_addr[1:0])
            2'd0:    merged[7:0]   = req_wdata[7:0];
            2'd1:    merged[15:8]  = req_wdata[7:0];
            2'd2:    merged[23:16] = req_wdata[7:0];
            default: merged[31:24] = req_wdata[7:0];
         endcase
      end else if (req_addr[1]) begin
         merged[31:16] = req_wdata[15:0];
      end else begin
         merged[15:0]  = req_wdata[15:0];
      end
   end

   always_comb begin
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      case (req_addr[1:0])
         2'd0:    lane_b = dm_rd[7:0];
         2'd1:    lane_b = dm_rd[15:8];
         2'd2:    lane_b = dm_rd[23:16];
         default: lane_b = dm_rd[31:24];
      endcase
      lane_h = req_addr[1] ? dm_rd[31:16] : dm_rd[15:0];
      case (req_size)
         2'd0:    load_ext = {{24{req_sign & lane_b[7]}}, lane_b};
         2'd1:    load_ext = {{16{req_sign & lane_h[15]}}, lane_h};
         default: load_ext = dm_rd;
      endcase
   end

   // NOTE: every output and next-state value gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      merge_d  = merge_q;
      waddr_d  = waddr_q;
      dm_a     = word_addr;
      dm_wd    = req_wdata;
      dm_we    = 1'b0;
      stall    = 1'b0;
      ld_valid = 1'b0;
      ld_data  = 32'd0;

      case (state_q)
         IDLE: begin
            if (ok && req_we) begin
               if (req_size == 2'd2) begin
                  dm_we = 1'b1;
               end else begin
                  stall   = 1'b1;
                  merge_d = merged;
                  waddr_d = word_addr;
                  state_d = RMW_WR;
               end
            end else if (ok) begin
               ld_valid = 1'b1;
               ld_data  = load_ext;
            end
         end
         RMW_WR: begin
            dm_we   = 1'b1;
            dm_wd   = merge_q;
            dm_a    = waddr_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Reset must suppress strobes immediately, including an in-flight RMW write.
      if (reset) begin
         dm_we    = 1'b0;
         dm_wd    = 32'd0;
         stall    = 1'b0;
         ld_valid = 1'b0;
         ld_data  = 32'd0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         merge_q <= 32'd0;
         waddr_q <= 32'd0;
      end else begin
         state_q <= state_d;
         merge_q <= merge_d;
         waddr_q <= waddr_d;
      end
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits in the M stage between the EX/MEM pipeline register and the data memory (3072 x 32-bit words, little-endian, synchronous write, combinational read).
- Converts M-stage load/store requests of byte, half and word size into word-aligned memory accesses.
- Sub-word stores are done as a 2-cycle read-modify-write, and the unit stalls the pipeline during that time.
- Extends load data, and flags misaligned or out-of-range accesses.

Parameters:
- DM_WORDS, 3072, number of 32-bit words in the data memory; legal byte addresses are 0 .. 4*DM_WORDS-1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  M-stage memory instruction present
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_sign  input  1  load sign-extend enable (lb/lh vs lbu/lhu)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- req_pc  input  32  PC of the M-stage instruction
- dm_rd  input  32  word read from data memory at dm_a
- dm_a  output  32  word-aligned address to data memory ({req_addr[31:2],2'b00})
- dm_wd  output  32  write data to data memory
- dm_we  output  1  data memory write enable
- dm_pc  output  32  PC forwarded to the data memory for the write log (= req_pc)
- stall  output  1  holds the pipeline upstream of M
- ld_data  output  32  extended load result
- ld_valid  output  1  ld_data is valid this cycle
- exc_adel  output  1  load address error
- exc_ades  output  1  store address error

Behaviour:
- Request validity:
  - misaligned = (size==1 && addr[0]) || (size==2 && addr[1:0]!=0) || size==3.
  - oor = addr >= 4*DM_WORDS.
  - ok = req_valid && !misaligned && !oor.
- Address errors:
  - exc_adel = req_valid && !req_we && !ok.
  - exc_ades = req_valid && req_we && !ok.
  - A faulting request never writes, never stalls, and holds ld_valid=0.
- FSM states:
  - IDLE, RMW_WR. Reset → IDLE, asynchronously.
  - Merge register (32b) and saved word address reset to 0.
- IDLE, word store (ok, size 2):
  - dm_we=1 and dm_wd=req_wdata in the same cycle.
  - stall=0; stay in IDLE.
- IDLE, sub-word store (ok, size 0/1):
  - dm_we=0 and stall=1.
  - merge register <= dm_rd with the target lane replaced.
    - Byte: lane addr[1:0], data req_wdata[7:0].
    - Half: lanes addr[1]*2 +{0,1}, data req_wdata[15:0].
  - → RMW_WR.
- RMW_WR:
  - dm_we=1, dm_wd=merge register, dm_a=saved word address.
  - stall=0; → IDLE.
  - Upstream holds the request stable while stall=1. The following instruction enters M on the next cycle.
- Loads (ok, !req_we): single cycle, combinational from dm_rd, in IDLE only.
  - ld_valid=1.
  - Byte result: lane addr[1:0], zero- or sign-extended by req_sign.
  - Half result: half addr[1], extended the same way.
  - Word result: dm_rd unchanged.
  - No state change.
- While reset is high:
  - dm_we=0, stall=0, ld_valid=0, exc_*=0, dm_wd=0.
  - Reset asserted in RMW_WR aborts the write; the memory word is unchanged.
- Write timing: the data memory commits on the posedge at which dm_we=1. A load issued in the next cycle sees the new data.
- req_valid=0: all strobes are 0 and the FSM stays in IDLE.

Test Plan:
- Word store: sw, addr 0x10, data 0x11223344 → same cycle dm_we=1, dm_a=0x10, dm_wd=0x11223344, stall=0. A following lw at 0x10 gives ld_data=0x11223344, ld_valid=1.
- Byte store: sb, addr 0x11, data 0x000000AB, memory word 0x11223344.
  - Cycle 1: stall=1, dm_we=0.
  - Cycle 2: dm_we=1, dm_a=0x10, dm_wd=0x1122AB44, stall=0.
- Load extension on word 0x1122AB44 at 0x10:
  - lb signed at 0x11 → 0xFFFFFFAB; lbu at 0x11 → 0x000000AB.
  - lh signed at 0x10 → 0xFFFFAB44; lhu at 0x12 → 0x00001122.
- Misalignment: sw at 0x12 → exc_ades=1, dm_we=0, stall=0. lh at 0x13 → exc_adel=1, ld_valid=0. size=3 → the matching exc flag is set.
- Out of range: lw at 0x3000 → exc_adel=1, ld_valid=0. sb at 0x3001 → exc_ades=1, no stall, no write.
- Reset during read-modify-write: sh at 0x20 (word 0) enters RMW_WR, then reset is pulsed mid-cycle.
  - dm_we drops immediately and the state returns to IDLE.
  - After reset deasserts, lw 0x20 → 0x00000000.
